// File: rtl/intersection_controller.sv
// Two-way intersection signal controller with pedestrian walk phase.
// Moore outputs are decoded from the state register; a 16-bit dwell counter times every phase.
module intersection_controller #(
   parameter int unsigned GREEN_MIN   = 10,
   parameter int unsigned GREEN_MAX   = 50,
   parameter int unsigned YELLOW_TIME = 5,
   parameter int unsigned ALLRED_TIME = 2,
   parameter int unsigned PED_TIME    = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sensor_ns,
   input  logic       sensor_ew,
   input  logic       ped_req,
   output logic [1:0] light_ns,
   output logic [1:0] light_ew,
   output logic       walk,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      S_NSG   = 3'd0,
      S_NSY   = 3'd1,
      S_AR_NS = 3'd2,
      S_EWG   = 3'd3,
      S_EWY   = 3'd4,
      S_AR_EW = 3'd5,
      S_WALK  = 3'd6
   } state_e;

   typedef enum logic {
      DIR_NS = 1'b0,
      DIR_EW = 1'b1
   } dir_e;

   localparam logic [1:0] LIGHT_RED    = 2'b01;
   localparam logic [1:0] LIGHT_YELLOW = 2'b10;
   localparam logic [1:0] LIGHT_GREEN  = 2'b11;

   // Terminal counter values: a dwell of N cycles ends on the cycle whose count is N-1.
   localparam logic [15:0] GMIN_LAST = 16'(GREEN_MIN - 1);
   localparam logic [15:0] GMAX_LAST = 16'(GREEN_MAX - 1);
   localparam logic [15:0] YEL_LAST  = 16'(YELLOW_TIME - 1);
   localparam logic [15:0] AR_LAST   = 16'(ALLRED_TIME - 1);
   localparam logic [15:0] PED_LAST  = 16'(PED_TIME - 1);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        ped_pending_q, ped_pending_d;
   dir_e        last_dir_q, last_dir_d;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_AR_EW;
         cnt_q         <= 16'd0;
         ped_pending_q <= 1'b0;
         last_dir_q    <= DIR_EW;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         ped_pending_q <= ped_pending_d;
         last_dir_q    <= last_dir_d;
      end
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      last_dir_d = last_dir_q;

      unique case (state_q)
         S_NSG: begin
            if ((sensor_ew || ped_pending_q) &&
                ((cnt_q >= GMIN_LAST && !sensor_ns) || cnt_q >= GMAX_LAST))
               state_d = S_NSY;
         end
         S_NSY: begin
            if (cnt_q == YEL_LAST) state_d = S_AR_NS;
         end
         S_AR_NS: begin
            if (cnt_q == AR_LAST) begin
               last_dir_d = DIR_NS;
               state_d    = ped_pending_q ? S_WALK : S_EWG;
            end
         end
         S_EWG: begin
            if ((sensor_ns || ped_pending_q) &&
                ((cnt_q >= GMIN_LAST && !sensor_ew) || cnt_q >= GMAX_LAST))
               state_d = S_EWY;
         end
         S_EWY: begin
            if (cnt_q == YEL_LAST) state_d = S_AR_EW;
         end
         S_AR_EW: begin
            if (cnt_q == AR_LAST) begin
               last_dir_d = DIR_EW;
               state_d    = ped_pending_q ? S_WALK : S_NSG;
            end
         end
         S_WALK: begin
            if (cnt_q == PED_LAST) state_d = (last_dir_q == DIR_NS) ? S_EWG : S_NSG;
         end
         default: state_d = S_AR_EW;
      endcase

      // Counter restarts on any state change, otherwise counts up and saturates.
      if (state_d != state_q)      cnt_d = 16'd0;
      else if (cnt_q == 16'hFFFF)  cnt_d = cnt_q;
      else                         cnt_d = cnt_q + 16'd1;

      // Entering WALK serves the request and wins over a simultaneous new press.
      if (state_d == S_WALK && state_q != S_WALK) ped_pending_d = 1'b0;
      else if (ped_req && state_q != S_WALK)      ped_pending_d = 1'b1;
      else                                        ped_pending_d = ped_pending_q;
   end

   always_comb begin
      light_ns = LIGHT_RED;
      light_ew = LIGHT_RED;
      walk     = 1'b0;
      phase    = state_q;
      unique case (state_q)
         S_NSG:   light_ns = LIGHT_GREEN;
         S_NSY:   light_ns = LIGHT_YELLOW;
         S_EWG:   light_ew = LIGHT_GREEN;
         S_EWY:   light_ew = LIGHT_YELLOW;
         S_WALK:  walk     = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_intersection_controller.sv
// Directed bench for intersection_controller at default timing parameters.
// Each observation packs {light_ns, light_ew, walk, phase} into one byte.
module tb_intersection_controller;

   logic       clk;
   logic       reset;
   logic       sensor_ns;
   logic       sensor_ew;
   logic       ped_req;
   logic [1:0] light_ns;
   logic [1:0] light_ew;
   logic       walk;
   logic [2:0] phase;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [7:0] E_NSG   = {2'b11, 2'b01, 1'b0, 3'd0};
   localparam logic [7:0] E_NSY   = {2'b10, 2'b01, 1'b0, 3'd1};
   localparam logic [7:0] E_AR_NS = {2'b01, 2'b01, 1'b0, 3'd2};
   localparam logic [7:0] E_EWG   = {2'b01, 2'b11, 1'b0, 3'd3};
   localparam logic [7:0] E_EWY   = {2'b01, 2'b10, 1'b0, 3'd4};
   localparam logic [7:0] E_AR_EW = {2'b01, 2'b01, 1'b0, 3'd5};
   localparam logic [7:0] E_WALK  = {2'b01, 2'b01, 1'b1, 3'd6};

   intersection_controller dut (
      .clk       (clk),
      .reset     (reset),
      .sensor_ns (sensor_ns),
      .sensor_ew (sensor_ew),
      .ped_req   (ped_req),
      .light_ns  (light_ns),
      .light_ew  (light_ew),
      .walk      (walk),
      .phase     (phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] outs();
      return {light_ns, light_ew, walk, phase};
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Check the same output pattern for n consecutive cycles, advancing one clock each.
   task automatic hold(input string tag, input logic [7:0] exp, input int n);
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s[%0d]", tag, i), outs(), exp);
         @(posedge clk);
         #1;
      end
   endtask

   // Synchronous-looking reset pulse; leaves the bench at AR_EW cycle 0.
   task automatic do_reset(input string tag);
      reset = 1'b1;
      #1;
      check({tag, "_async"}, outs(), E_AR_EW);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Safety invariants sampled every cycle away from the active edge.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         check("no_conflict_walk_ok",
               {6'b0, light_ns[1] & light_ew[1],
                walk & !(light_ns == 2'b01 && light_ew == 2'b01)},
               8'h00);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b0;
      sensor_ns = 1'b0;
      sensor_ew = 1'b0;
      ped_req   = 1'b0;

      // Power-on reset asserted between clock edges: outputs must react at once.
      #2;
      reset = 1'b1;
      #1;
      check("por_async", outs(), E_AR_EW);
      @(posedge clk);
      #1;
      check("por_held", outs(), E_AR_EW);
      reset = 1'b0;

      // Idle: all-red for ALLRED_TIME, then NS green held with no demand.
      hold("idle_ar", E_AR_EW, 2);
      hold("idle_nsg", E_NSG, 205);

      // EW demand from NSG cycle 0: minimum green, yellow, all-red, EW green.
      do_reset("r2");
      hold("gap_ar", E_AR_EW, 2);
      sensor_ew = 1'b1;
      hold("gap_nsg", E_NSG, 10);
      hold("gap_nsy", E_NSY, 5);
      hold("gap_arns", E_AR_NS, 2);
      hold("gap_ewg", E_EWG, 8);

      // Both approaches occupied: NS green maxes out at GREEN_MAX.
      sensor_ns = 1'b0;
      sensor_ew = 1'b0;
      do_reset("r3");
      hold("max_ar", E_AR_EW, 2);
      sensor_ns = 1'b1;
      sensor_ew = 1'b1;
      hold("max_nsg", E_NSG, 50);
      hold("max_nsy", E_NSY, 5);
      hold("max_arns", E_AR_NS, 2);
      hold("max_ewg", E_EWG, 3);

      // Pedestrian press in NSG cycle 3; a press during WALK must not repeat WALK.
      sensor_ns = 1'b0;
      sensor_ew = 1'b0;
      do_reset("r4");
      hold("ped_ar", E_AR_EW, 2);
      hold("ped_nsg_a", E_NSG, 3);
      ped_req = 1'b1;
      hold("ped_nsg_b", E_NSG, 1);
      ped_req = 1'b0;
      hold("ped_nsg_c", E_NSG, 6);
      hold("ped_nsy", E_NSY, 5);
      hold("ped_arns", E_AR_NS, 2);
      hold("ped_walk_a", E_WALK, 5);
      ped_req = 1'b1;
      hold("ped_walk_b", E_WALK, 1);
      ped_req = 1'b0;
      hold("ped_walk_c", E_WALK, 14);
      hold("ped_ewg", E_EWG, 30);

      // NS demand ends EW green; press in EWY then reset mid-yellow discards it.
      sensor_ns = 1'b1;
      hold("rst_ewg", E_EWG, 1);
      ped_req = 1'b1;
      hold("rst_ewy_a", E_EWY, 1);
      ped_req = 1'b0;
      hold("rst_ewy_b", E_EWY, 1);
      check("rst_ewy_c2", outs(), E_EWY);
      sensor_ns = 1'b0;
      do_reset("r5");
      hold("rst_ar", E_AR_EW, 2);
      hold("rst_nsg", E_NSG, 25);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/intersection_controller.md
INTERSECTION_CONTROLLER -- requirements
Module: intersection_controller

Interface
REQ-001 Parameter GREEN_MIN, default 10: minimum green dwell in clk cycles.
REQ-002 Parameter GREEN_MAX, default 50: maximum green dwell in clk cycles while opposing demand exists.
REQ-003 Parameter YELLOW_TIME, default 5: yellow dwell in clk cycles.
REQ-004 Parameter ALLRED_TIME, default 2: all-red clearance dwell in clk cycles.
REQ-005 Parameter PED_TIME, default 20: pedestrian walk dwell in clk cycles.
REQ-006 Parameter legality: all durations 1..65535; GREEN_MIN <= GREEN_MAX; dwell counter 16 bits.
REQ-007 clk  input  1  single clock; all state changes on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 sensor_ns  input  1  vehicle present on north-south approach, level, synchronous to clk.
REQ-010 sensor_ew  input  1  vehicle present on east-west approach, level, synchronous to clk.
REQ-011 ped_req  input  1  pedestrian button, one or more cycles high, synchronous to clk.
REQ-012 light_ns  output  2  NS signal head: 01 red, 10 yellow, 11 green.
REQ-013 light_ew  output  2  EW signal head, same encoding.
REQ-014 walk  output  1  pedestrian walk indication.
REQ-015 phase  output  3  current state code.

Function
REQ-016 States/codes: NSG=0, NSY=1, AR_NS=2, EWG=3, EWY=4, AR_EW=5, WALK=6; code 7 is illegal and SHALL transition to AR_EW with cnt=0 on the next edge.
REQ-017 cnt: 16-bit up-counter, 0 in the first cycle of every state, +1 per cycle, saturating at 65535.
REQ-018 Outputs SHALL be Moore-decoded from the state register only: NSG -> ns=11/ew=01; NSY -> 10/01; EWG -> 01/11; EWY -> 01/10; AR_NS, AR_EW, WALK -> 01/01; walk=1 only in WALK; phase = state code.
REQ-019 A green and a yellow SHALL never be driven on both heads simultaneously in any cycle.
REQ-020 ped_pending flag: set on any cycle with ped_req=1 and state != WALK; cleared on the edge entering WALK; clear has priority over set on that edge; ped_req while in WALK is ignored.
REQ-021 Demand for leaving NSG: dem = sensor_ew | ped_pending; for EWG: dem = sensor_ns | ped_pending.
REQ-022 Green exit: leave NSG (to NSY) / EWG (to EWY) when dem=1 and either (cnt >= GREEN_MIN-1 and own-approach sensor=0) or cnt >= GREEN_MAX-1; with dem=0 green SHALL be held indefinitely.
REQ-023 NSY -> AR_NS and EWY -> AR_EW when cnt = YELLOW_TIME-1.
REQ-024 AR_NS exit at cnt = ALLRED_TIME-1: to WALK if ped_pending, else EWG; AR_EW exit likewise: to WALK if ped_pending, else NSG.
REQ-025 last_dir register records the direction of the all-red just left (NS or EW); WALK exits at cnt = PED_TIME-1 to EWG if last_dir=NS, else NSG.
REQ-026 Dwell times are exact: every non-green state is occupied for exactly its parameter count of cycles.

Reset
REQ-027 While reset=1, immediately and asynchronously: state=AR_EW, cnt=0, ped_pending=0, last_dir=EW; outputs light_ns=01, light_ew=01, walk=0, phase=5.
REQ-028 After reset deassertion, the block SHALL spend ALLRED_TIME cycles in AR_EW and then enter NSG (ped_pending is 0).
REQ-029 Reset asserted in any state, including mid-dwell, SHALL abandon the current dwell with no residual pedestrian request.

Verification
REQ-030 Reset release, all inputs 0 -> 01/01 for 2 cycles, then NSG (11/01), held for 200+ cycles.
REQ-031 In NSG, sensor_ns=0 and sensor_ew=1 from NSG cycle 0 -> 10 cycles 11/01, 5 cycles 10/01, 2 cycles 01/01, then 01/11.
REQ-032 In NSG, sensor_ns=1 and sensor_ew=1 held -> NS green exactly 50 cycles (max-out), then yellow 5 and all-red 2, then EWG.
REQ-033 1-cycle ped_req in NSG cycle 3, sensors 0 -> NSY at cycle 10, AR_NS 2 cycles, WALK 20 cycles (walk=1, 01/01), then EWG; ped_req pulsed during WALK -> no second WALK.
REQ-034 Reset asserted in EWY cycle 2 -> same cycle outputs 01/01, phase=5, walk=0; after release, AR_EW 2 cycles then NSG.
REQ-035 Every cycle of all scenarios: no cycle with both heads in {10,11}; walk=1 only when both heads are 01.
